// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - stall/flush request inputs and pipeline-register control outputs
// master drives the hazard/cache requests; slave is the scheduler that answers with enables and flushes.
interface pipeline_ctrl_if;
  logic       is_hazard;
  logic       mispredict;
  logic       ecall_halt;
  logic       icache_ready;
  logic       dcache_req;
  logic       dcache_ready;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_write;
  logic       mem_wb_write;
  logic       is_halted;
  logic [1:0] state;

  modport master (
    output is_hazard, mispredict, ecall_halt, icache_ready, dcache_req, dcache_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_write, is_halted, state
  );

  modport slave (
    input  is_hazard, mispredict, ecall_halt, icache_ready, dcache_req, dcache_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_write, is_halted, state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler and end-of-program drain sequencer for the 5-stage pipeline
// Optional stall/flush/dmiss counters are built when PIPE_STALL_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   pif
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] dmiss_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DMISS  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            freeze;

  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_write, is_halted;

  assign freeze = pif.dcache_req & ~pif.dcache_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // The D-miss release cycle is a real pipeline advance, so a pending drain counts it.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = DMISS;
          ret_d   = RUN;
        end else if (pif.ecall_halt) begin
          cnt_d   = DW'(DRAIN_CYCLES);
          state_d = DRAIN;
        end
      end
      DMISS: begin
        if (!freeze) begin
          if (ret_q == DRAIN) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == DW'(1)) ? HALTED : DRAIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      DRAIN: begin
        if (freeze) begin
          state_d = DMISS;
          ret_d   = DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DW'(1)) state_d = HALTED;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    is_halted    = 1'b0;
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == HALTED || freeze) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
      is_halted = (state_q == HALTED);
    end else if (state_q == DRAIN || (state_q == DMISS && ret_q == DRAIN) ||
                 (state_q == RUN && pif.ecall_halt)) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == RUN) begin
      if (pif.mispredict) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (pif.is_hazard) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!pif.icache_ready) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  assign pif.pc_write     = pc_write;
  assign pif.if_id_write  = if_id_write;
  assign pif.if_id_flush  = if_id_flush;
  assign pif.id_ex_write  = id_ex_write;
  assign pif.id_ex_flush  = id_ex_flush;
  assign pif.ex_mem_write = ex_mem_write;
  assign pif.mem_wb_write = mem_wb_write;
  assign pif.is_halted    = is_halted;
  assign pif.state        = state_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [CNT_W-1:0] dmiss_cycles_q, dmiss_cycles_d;
  logic             stall_inc, flush_inc, dmiss_inc;

  assign stall_inc = (state_q == RUN || state_q == DMISS) & ~pc_write;
  assign flush_inc = (state_q == RUN) & ~freeze & ~pif.ecall_halt & pif.mispredict;
  assign dmiss_inc = (state_q != HALTED) & freeze;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    dmiss_cycles_d = dmiss_cycles_q;
    if (stall_inc && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush_inc && !(&flush_count_q))  flush_count_d  = flush_count_q + 1'b1;
    if (dmiss_inc && !(&dmiss_cycles_q)) dmiss_cycles_d = dmiss_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      dmiss_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      dmiss_cycles_q <= dmiss_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign dmiss_cycles = dmiss_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized check of pipeline_ctrl against a table-driven reference model
// Counter checks are compiled in when PIPE_STALL_CNT_EN is defined.
module tb_pipeline_ctrl;
  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 32;

  // Control vector order: {pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_w, halted}
  localparam logic [7:0] O_ADV   = 8'b1101_0110;
  localparam logic [7:0] O_FRZ   = 8'b0000_0000;
  localparam logic [7:0] O_RST   = 8'b0010_1000;
  localparam logic [7:0] O_HALT  = 8'b0000_0001;
  localparam logic [7:0] O_DRN   = 8'b0111_1110;
  localparam logic [7:0] O_MISP  = 8'b1111_1110;
  localparam logic [7:0] O_HAZ   = 8'b0001_1110;
  localparam logic [7:0] O_IMISS = 8'b0111_0110;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if pif ();

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_count, dmiss_cycles;
`endif

  pipeline_ctrl #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pif  (pif)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count),
    .dmiss_cycles(dmiss_cycles)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 run, 1 waiting on D-cache, 2 draining, 3 halted.
  int m_mode = 0;
  int m_ret  = 0;
  int m_left = 0;
  int e_stall = 0;
  int e_flush = 0;
  int e_dmiss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval(input logic rst, hz, mp, ec, ic, dq, dr, output logic [7:0] ctl);
    bit frz;
    int cur;
    frz = dq && !dr;
    cur = m_mode;
    ctl = O_ADV;
    if (rst) begin
      ctl = O_RST;
      m_mode = 0; m_ret = 0; m_left = 0;
      e_stall = 0; e_flush = 0; e_dmiss = 0;
      return;
    end
    if (cur == 3) begin
      ctl = O_HALT;
    end else if (frz) begin
      ctl = O_FRZ;
      if (cur != 1) begin
        m_ret  = cur;
        m_mode = 1;
      end
    end else if (cur == 2 || (cur == 1 && m_ret == 2) || (cur == 0 && ec)) begin
      ctl = O_DRN;
      if (cur == 0) begin
        m_left = DRAIN_CYCLES;
        m_mode = 2;
      end else begin
        m_left = m_left - 1;
        m_mode = (m_left == 0) ? 3 : 2;
      end
    end else if (cur == 1) begin
      m_mode = 0;
    end else if (mp) begin
      ctl = O_MISP;
      e_flush++;
    end else if (hz) begin
      ctl = O_HAZ;
    end else if (!ic) begin
      ctl = O_IMISS;
    end
    if (frz && cur != 3) e_dmiss++;
    if (cur <= 1 && !ctl[7]) e_stall++;
  endtask

  task automatic step(input logic rst, hz, mp, ec, ic, dq, dr);
    logic [7:0] exp_ctl;
    logic [7:0] got_ctl;
    @(negedge clk);
    reset            = rst;
    pif.is_hazard    = hz;
    pif.mispredict   = mp;
    pif.ecall_halt   = ec;
    pif.icache_ready = ic;
    pif.dcache_req   = dq;
    pif.dcache_ready = dr;
    #1;
    check_eq("state", 32'(pif.state), 32'(m_mode));
`ifdef PIPE_STALL_CNT_EN
    check_eq("stall_cycles", stall_cycles, 32'(e_stall));
    check_eq("flush_count", flush_count, 32'(e_flush));
    check_eq("dmiss_cycles", dmiss_cycles, 32'(e_dmiss));
`endif
    model_eval(rst, hz, mp, ec, ic, dq, dr, exp_ctl);
    got_ctl = {pif.pc_write, pif.if_id_write, pif.if_id_flush, pif.id_ex_write,
               pif.id_ex_flush, pif.ex_mem_write, pif.mem_wb_write, pif.is_halted};
    check_eq("ctl", 32'(got_ctl), 32'(exp_ctl));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    pif.is_hazard    = 1'b0;
    pif.mispredict   = 1'b0;
    pif.ecall_halt   = 1'b0;
    pif.icache_ready = 1'b1;
    pif.dcache_req   = 1'b0;
    pif.dcache_ready = 1'b0;
    repeat (2) @(posedge clk);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // load-use, then icache miss
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // D-miss for 3 cycles then ready
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();

    // mispredict + hazard together
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // ecall drain into HALTED
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    check_eq("t4_is_halted", 32'(pif.is_halted), 32'd1);
    idle();

    // D-miss inside drain, then reset out of HALTED
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    idle();
    check_eq("t5_halted_state", 32'(pif.state), 32'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check_eq("t5_reset_exit", 32'(pif.is_halted), 32'd0);

    // D-miss on the last drain cycle: release retires straight into HALTED
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();

    // counters: 4 hazards + 2 mispredicts, then halt and idle
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-DMISS with a drain saved: saved state must be discarded
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();

    for (int i = 0; i < 4000; i++) begin
      logic rst, hz, mp, ec, ic, dq, dr;
      rst = (m_mode == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
      hz  = ($urandom_range(0, 3) == 0);
      mp  = ($urandom_range(0, 5) == 0);
      ec  = ($urandom_range(0, 29) == 0);
      ic  = ($urandom_range(0, 4) != 0);
      dq  = ($urandom_range(0, 2) == 0);
      dr  = 1'($urandom_range(0, 1));
      step(rst, hz, mp, ec, ic, dq, dr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
